// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default geometry and binary/Gray conversions,
// used by both the write-pointer and read-pointer control blocks.
package fifo_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;
  localparam int DEFAULT_DEPTH     = 1 << DEFAULT_PTR_WIDTH;

  // Helpers work on a wide word; callers zero-extend in and truncate out,
  // which leaves the low bits of both conversions unchanged.
  localparam int MAX_PTR_BITS = 32;
  typedef logic [MAX_PTR_BITS-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[MAX_PTR_BITS-1] = gray[MAX_PTR_BITS-1];
    for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a bus whose source is Gray coded (at most one
// bit changes per source step); synchronous active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge and the chain really is two deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/level logic of an async FIFO.
// Optional almost_full output is built only when WPTR_ALMOST_FULL_EN is defined.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH,
  parameter int AF_THRESH = 6
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic [PTR_WIDTH:0] wr_level,
  output logic               overflow
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic               almost_full
`endif
);

  localparam int PW = PTR_WIDTH + 1;
  // Full in Gray space: pointers differ only in their two top bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  if (DEPTH != (1 << PTR_WIDTH) || AF_THRESH < 1 || AF_THRESH >= DEPTH) begin : g_param_check
    $error("wptr_full_ctrl: DEPTH must be 2**PTR_WIDTH and AF_THRESH in 1..DEPTH-1");
  end

  logic [PW-1:0] r_b_wptr;
  logic [PW-1:0] r_g_wptr;
  logic          r_full;
  logic [PW-1:0] r_wr_level;
  logic          r_overflow;

  logic [PW-1:0] w_rptr_sync;
  logic [PW-1:0] w_rptr_bin;
  logic [PW-1:0] w_b_wptr_next;
  logic [PW-1:0] w_g_wptr_next;
  logic [PW-1:0] w_level_next;
  logic          w_accept;
  logic          w_full_next;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .i_d (g_rptr),
    .o_q (w_rptr_sync)
  );

  always_comb begin
    w_accept      = w_en & ~r_full;
    w_b_wptr_next = r_b_wptr + PW'(w_accept);
    w_g_wptr_next = PW'(bin2gray(ptr_word_t'(w_b_wptr_next)));
    w_rptr_bin    = PW'(gray2bin(ptr_word_t'(w_rptr_sync)));
    w_level_next  = w_b_wptr_next - w_rptr_bin;
    w_full_next   = (w_g_wptr_next ^ w_rptr_sync) == FULL_MASK;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_b_wptr   <= '0;
      r_g_wptr   <= '0;
      r_full     <= 1'b0;
      r_wr_level <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_b_wptr   <= w_b_wptr_next;
      r_g_wptr   <= w_g_wptr_next;
      r_full     <= w_full_next;
      r_wr_level <= w_level_next;
      r_overflow <= r_overflow | (w_en & r_full);
    end
  end

  assign b_wptr   = r_b_wptr;
  assign g_wptr   = r_g_wptr;
  assign full     = r_full;
  assign wr_level = r_wr_level;
  assign overflow = r_overflow;

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

  logic r_almost_full;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= AF_LEVEL);
    end
  end

  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl with default geometry (DEPTH 8, PTR_WIDTH 3).
// almost_full checks are compiled in when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       w_en;
  logic [3:0] g_rptr;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic [3:0] wr_level;
  logic       overflow;
`ifdef WPTR_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Hand-written 4-bit Gray code table, index = binary value.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  wptr_full_ctrl #(
    .DEPTH     (8),
    .PTR_WIDTH (3),
    .AF_THRESH (6)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .g_rptr      (g_rptr),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .full        (full),
    .wr_level    (wr_level),
    .overflow    (overflow)
`ifdef WPTR_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic tick(input logic en, input logic [3:0] gr);
    w_en   = en;
    g_rptr = gr;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst   = 1'b1;
    w_en   = 1'b0;
    g_rptr = 4'h0;

    // Reset with a write request held: the request must be ignored.
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    check("rst b_wptr", b_wptr, 0);
    check("rst g_wptr", g_wptr, 0);
    check("rst full", full, 0);
    check("rst wr_level", wr_level, 0);
    check("rst overflow", overflow, 0);
`ifdef WPTR_ALMOST_FULL_EN
    check("rst almost_full", almost_full, 0);
`endif
    wrst = 1'b0;

    // Eight writes with the reader parked at 0: full lands right after the 8th.
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 4'h0);
      check($sformatf("fill%0d b_wptr", k), b_wptr, k);
      check($sformatf("fill%0d g_wptr", k), g_wptr, gray_tab[k]);
      check($sformatf("fill%0d wr_level", k), wr_level, k);
      check($sformatf("fill%0d full", k), full, (k == 8) ? 1 : 0);
`ifdef WPTR_ALMOST_FULL_EN
      check($sformatf("fill%0d almost_full", k), almost_full, (k >= 6) ? 1 : 0);
`endif
    end
    check("full g_wptr 1100", g_wptr, 4'b1100);

    // Write while full: pointers hold, overflow latches.
    tick(1'b1, 4'h0);
    check("ovf b_wptr", b_wptr, 8);
    check("ovf g_wptr", g_wptr, 4'b1100);
    check("ovf overflow", overflow, 1);
    check("ovf full", full, 1);

    // Reader advances to 1: full stays up for two edges, drops on the third.
    tick(1'b0, 4'h1);
    check("rd1 edge1 full", full, 1);
    tick(1'b0, 4'h1);
    check("rd1 edge2 full", full, 1);
    check("rd1 edge2 wr_level", wr_level, 8);
    tick(1'b0, 4'h1);
    check("rd1 edge3 full", full, 0);
    check("rd1 edge3 wr_level", wr_level, 7);
    check("rd1 overflow sticky", overflow, 1);
`ifdef WPTR_ALMOST_FULL_EN
    check("rd1 almost_full", almost_full, 1);
`endif

    // Reader to 3: level 5, almost_full drops, overflow still set.
    tick(1'b0, gray_tab[3]);
    tick(1'b0, gray_tab[3]);
    tick(1'b0, gray_tab[3]);
    check("rd3 wr_level", wr_level, 5);
    check("rd3 overflow sticky", overflow, 1);
`ifdef WPTR_ALMOST_FULL_EN
    check("rd3 almost_full", almost_full, 0);
`endif

    // Reader catches up to 8: FIFO empty.
    tick(1'b0, gray_tab[8]);
    tick(1'b0, gray_tab[8]);
    tick(1'b0, gray_tab[8]);
    check("rd8 wr_level", wr_level, 0);
    check("rd8 full", full, 0);

    // Eight more writes with the reader trailing: pointer wraps 15 -> 0.
    for (int k = 9; k <= 16; k++) begin
      tick(1'b1, gray_tab[(k - 1) % 16]);
      check($sformatf("wrap%0d b_wptr", k), b_wptr, k % 16);
      check($sformatf("wrap%0d g_wptr", k), g_wptr, gray_tab[k % 16]);
      check($sformatf("wrap%0d full", k), full, 0);
    end
    check("wrap b_wptr zero", b_wptr, 0);
    check("wrap g_wptr zero", g_wptr, 0);

    tick(1'b0, gray_tab[0]);
    tick(1'b0, gray_tab[0]);
    tick(1'b0, gray_tab[0]);
    check("wrap drain wr_level", wr_level, 0);
    check("wrap drain full", full, 0);

    // Five writes, then reset mid-operation with a write and a live reader pointer.
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 4'h0);
    end
    check("pre-rst b_wptr", b_wptr, 5);
    check("pre-rst wr_level", wr_level, 5);

    wrst = 1'b1;
    tick(1'b1, gray_tab[4]);
    check("midrst b_wptr", b_wptr, 0);
    check("midrst g_wptr", g_wptr, 0);
    check("midrst full", full, 0);
    check("midrst wr_level", wr_level, 0);
    check("midrst overflow", overflow, 0);
`ifdef WPTR_ALMOST_FULL_EN
    check("midrst almost_full", almost_full, 0);
`endif

    // First edge after reset release accepts the write.
    wrst = 1'b0;
    tick(1'b1, 4'h0);
    check("post-rst b_wptr", b_wptr, 1);
    check("post-rst g_wptr", g_wptr, 1);
    check("post-rst wr_level", wr_level, 1);
    check("post-rst overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entry count; SHALL equal 2**PTR_WIDTH.
REQ-002 Parameter PTR_WIDTH, default 3: memory address width; pointers SHALL be PTR_WIDTH+1 bits.
REQ-003 Parameter AF_THRESH, default 6: almost-full level threshold, range 1..DEPTH-1.
REQ-004 wclk  input  1: sole clock; one clock, all state on rising edge.
REQ-005 wrst  input  1: reset, synchronous, active-high.
REQ-006 w_en  input  1: write request from producer.
REQ-007 g_rptr  input  PTR_WIDTH+1: Gray read pointer from the read domain, asynchronous to wclk.
REQ-008 b_wptr  output  PTR_WIDTH+1: binary write pointer to the memory stage; low PTR_WIDTH bits address it.
REQ-009 g_wptr  output  PTR_WIDTH+1: Gray write pointer, to be synchronised by the read domain.
REQ-010 full  output  1: FIFO full; memory stage SHALL gate writes with it.
REQ-011 wr_level  output  PTR_WIDTH+1: occupancy seen from the write side, 0..DEPTH.
REQ-012 overflow  output  1: sticky flag, write attempted while full.
REQ-013 almost_full  output  1: present only under WPTR_ALMOST_FULL_EN.

Function
REQ-014 g_rptr SHALL pass through a 2-flop synchroniser clocked by wclk before any use; rptr_sync is stage-2 output.
REQ-015 Write accepted when w_en=1 and full=0; b_wptr SHALL increment by 1 modulo 2**(PTR_WIDTH+1) on the next wclk edge.
REQ-016 w_en=1 with full=1 SHALL leave b_wptr, g_wptr unchanged and set overflow on the next edge.
REQ-017 g_wptr SHALL be registered and always equal (b_wptr>>1)^b_wptr in the same cycle.
REQ-018 full SHALL be registered, computed from next Gray pointer: set when g_wptr_next equals rptr_sync with its top two bits inverted and the rest equal.
REQ-019 full SHALL assert the cycle after the DEPTH-th unread write is accepted (zero extra latency).
REQ-020 full SHALL deassert no earlier than 2 wclk cycles after g_rptr advances (synchroniser latency); pessimistic, never optimistic.
REQ-021 wr_level SHALL be registered: b_wptr_next minus gray-to-binary(rptr_sync), modulo 2**(PTR_WIDTH+1).
REQ-022 Pointer wrap (all-ones to zero) SHALL be seamless; MSB toggles distinguish full from empty.
REQ-023 overflow SHALL remain set until reset; no other clear.

Reset
REQ-024 With wrst=1 at a wclk edge: b_wptr=0, g_wptr=0, full=0, wr_level=0, overflow=0, almost_full=0, both synchroniser stages=0.
REQ-025 Reset mid-operation SHALL discard in-flight state; w_en ignored while wrst=1; first write accepted on the first edge after wrst deasserts.

Configuration
REQ-026 Macro WPTR_ALMOST_FULL_EN defined: almost_full port exists, registered, 1 when next wr_level >= AF_THRESH, else 0.
REQ-027 Macro undefined: almost_full port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package fifo_pkg SHALL hold bin2gray and gray2bin functions and default DEPTH/PTR_WIDTH constants, shared with the read-pointer block.
REQ-029 Sub-module sync_2ff (parameterised width, synchronous active-high reset) SHALL implement REQ-014.

Verification
REQ-030 Reset, then 8 consecutive writes, g_rptr=0 -> b_wptr=8 (4'b1000), g_wptr=4'b1100, full=1 after 8th edge, wr_level=8.
REQ-031 Full, w_en=1 for 1 cycle -> b_wptr stays 8, overflow=1 and stays 1 after further reads.
REQ-032 Full, g_rptr changes 0->1 (Gray) -> full=0 exactly 3 edges later, wr_level=7.
REQ-033 16 writes interleaved with read-pointer tracking -> b_wptr wraps 15->0, g_wptr=0, full never falsely set.
REQ-034 WPTR_ALMOST_FULL_EN, AF_THRESH=6 -> almost_full=1 after 6th accepted write, 0 after level drops to 5.
REQ-035 Assert wrst at b_wptr=5 -> all outputs 0 next edge; write in same cycle as wrst ignored.
